// File: rtl/axi_mem_pkg.sv
// Shared constants, state enums and burst legality check for axi_burst_slave_mem.
// WRAP burst support is enabled by defining AXI_SLAVE_MEM_WRAP_EN.
package axi_mem_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

`ifdef AXI_SLAVE_MEM_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_e;

  // WRAP needs a power-of-two beat count of 2..16 words.
  function automatic logic burst_ok(
    input logic [1:0] burst,
    input logic [7:0] len
  );
    logic len_ok;
    len_ok = (len == 8'd1) || (len == 8'd3) ||
             (len == 8'd7) || (len == 8'd15);
    burst_ok = 1'b1;
    if (burst == 2'b11)
      burst_ok = 1'b0;
    if (burst == BURST_WRAP)
      burst_ok = WRAP_EN && len_ok;
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Next-word-index calculator for FIXED/INCR/WRAP bursts.
// Ports: cur/start word index, len (low 4 bits), burst type -> nxt index.
// WRAP stepping is only built when AXI_SLAVE_MEM_WRAP_EN is defined.
module axi_burst_addr_gen
  import axi_mem_pkg::*;
#(
  parameter int IW = 7
) (
  input  logic [IW-1:0] cur,
  input  logic [IW-1:0] start,
  input  logic [3:0]    len,
  input  logic [1:0]    burst,
  output logic [IW-1:0] nxt
);

  logic [IW-1:0] inc;
  logic [IW-1:0] wrap;

  assign inc = cur + IW'(1);

`ifdef AXI_SLAVE_MEM_WRAP_EN
  logic [IW-1:0] mask;
  // len is 2^k-1 for legal wraps, so it doubles as the offset mask.
  assign mask = IW'(len);
  assign wrap = (start & ~mask) | (inc & mask);
`else
  logic unused_wrap;
  assign wrap = inc;
  assign unused_wrap = ^{start, len};
`endif

  always_comb begin
    nxt = cur;
    unique case (1'b1)
      (burst == BURST_INCR): nxt = inc;
      (burst == BURST_WRAP): nxt = wrap;
      default:               nxt = cur;
    endcase
  end

endmodule

// File: rtl/axi_burst_slave_mem.sv
// AXI4 burst slave over an on-chip word memory; independent write and read FSMs.
// Ports: clk, reset (async high), AW/W/B and AR/R channels. Macro: AXI_SLAVE_MEM_WRAP_EN.
module axi_burst_slave_mem #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 128
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ID_WIDTH-1:0]     arid,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic [2:0]              arsize,
  input  logic [1:0]              arburst,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [ID_WIDTH-1:0]     rid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);
  import axi_mem_pkg::*;

  localparam int BW  = DATA_WIDTH / 8;
  localparam int OFF = $clog2(BW);
  localparam int IW  = $clog2(MEM_DEPTH);
  localparam logic [2:0] SIZE = 3'(OFF);

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  logic [IW-1:0] aw_idx, ar_idx;
  logic          unused_addr;

  assign aw_idx = awaddr[OFF +: IW];
  assign ar_idx = araddr[OFF +: IW];
  assign unused_addr = ^{awaddr, araddr};

  // ---------------- write path
  w_state_e          w_state, w_state_n;
  logic [IW-1:0]     w_idx, w_start, w_nxt;
  logic [7:0]        w_len, w_cnt;
  logic [1:0]        w_burst;
  logic [ID_WIDTH-1:0] w_id;
  logic              w_sup, w_err;
  logic              aw_hs, w_hs, b_hs, w_end, w_lerr;

  assign aw_hs  = awvalid & awready;
  assign w_hs   = wvalid & wready;
  assign b_hs   = bvalid & bready;
  assign w_end  = w_hs & (w_cnt == w_len);
  assign w_lerr = wlast ^ (w_cnt == w_len);

  axi_burst_addr_gen #(.IW(IW)) u_wgen (
    .cur   (w_idx),
    .start (w_start),
    .len   (w_len[3:0]),
    .burst (w_burst),
    .nxt   (w_nxt)
  );

  always_comb begin
    w_state_n = w_state;
    unique case (w_state)
      W_IDLE:  if (aw_hs) w_state_n = W_DATA;
      W_DATA:  if (w_end) w_state_n = W_RESP;
      W_RESP:  if (b_hs)  w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state <= W_IDLE;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= RESP_OKAY;
      w_id    <= '0;
      w_idx   <= '0;
      w_start <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_burst <= BURST_FIXED;
      w_sup   <= 1'b0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_state_n;
      awready <= (w_state_n == W_IDLE);
      wready  <= (w_state_n == W_DATA);
      bvalid  <= (w_state_n == W_RESP);
      if (aw_hs) begin
        w_id    <= awid;
        w_idx   <= aw_idx;
        w_start <= aw_idx;
        w_len   <= awlen;
        w_burst <= awburst;
        w_cnt   <= '0;
        w_err   <= 1'b0;
        w_sup   <= (awsize != SIZE) | ~burst_ok(awburst, awlen);
      end
      if (w_hs) begin
        w_idx <= w_nxt;
        w_cnt <= w_cnt + 8'd1;
        w_err <= w_err | w_lerr;
      end
      if (w_end) begin
        bid   <= w_id;
        bresp <= (w_sup | w_err | w_lerr) ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_hs && !w_sup) begin
      for (int b = 0; b < BW; b++) begin
        if (wstrb[b])
          mem[w_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read path
  r_state_e      r_state, r_state_n;
  logic [IW-1:0] r_idx, r_start, r_cur, r_base, r_nxt;
  logic [7:0]    r_len, r_cnt, r_len_sel;
  logic [1:0]    r_burst, r_burst_sel;
  logic          r_sup, ar_bad, r_idle;
  logic          ar_hs, r_hs, r_load, r_zero;

  assign ar_hs  = arvalid & arready;
  assign r_hs   = rvalid & rready;
  assign r_idle = (r_state == R_IDLE);
  assign ar_bad = (arsize != SIZE) | ~burst_ok(arburst, arlen);

  // In idle the generator steps from the incoming AR so beat 1 is ready.
  assign r_cur       = r_idle ? ar_idx  : r_idx;
  assign r_base      = r_idle ? ar_idx  : r_start;
  assign r_len_sel   = r_idle ? arlen   : r_len;
  assign r_burst_sel = r_idle ? arburst : r_burst;
  assign r_load      = ar_hs | (r_hs & ~rlast);
  assign r_zero      = r_idle ? ar_bad : r_sup;

  axi_burst_addr_gen #(.IW(IW)) u_rgen (
    .cur   (r_cur),
    .start (r_base),
    .len   (r_len_sel[3:0]),
    .burst (r_burst_sel),
    .nxt   (r_nxt)
  );

  always_comb begin
    r_state_n = r_state;
    unique case (r_state)
      R_IDLE:  if (ar_hs) r_state_n = R_DATA;
      R_DATA:  if (r_hs && rlast) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= R_IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rid     <= '0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      r_idx   <= '0;
      r_start <= '0;
      r_len   <= '0;
      r_cnt   <= '0;
      r_burst <= BURST_FIXED;
      r_sup   <= 1'b0;
    end else begin
      r_state <= r_state_n;
      arready <= (r_state_n == R_IDLE);
      rvalid  <= (r_state_n == R_DATA);
      if (ar_hs) begin
        rid     <= arid;
        r_len   <= arlen;
        r_burst <= arburst;
        r_start <= ar_idx;
        r_sup   <= ar_bad;
        r_cnt   <= '0;
        rlast   <= (arlen == 8'd0);
        rresp   <= ar_bad ? RESP_SLVERR : RESP_OKAY;
        r_idx   <= r_nxt;
      end
      if (r_hs) begin
        if (rlast) begin
          rlast <= 1'b0;
        end else begin
          r_cnt <= r_cnt + 8'd1;
          rlast <= (r_cnt + 8'd1 == r_len);
          r_idx <= r_nxt;
        end
      end
      if (r_load)
        rdata <= r_zero ? '0 : mem[r_cur];
    end
  end

endmodule

// File: tb/tb_axi_burst_slave_mem.sv
// Self-checking bench for axi_burst_slave_mem: directed table, hand sequences,
// and randomized bursts against a word-array reference model.
module tb_axi_burst_slave_mem;

  localparam int D = 128;

`ifdef AXI_SLAVE_MEM_WRAP_EN
  localparam bit WRAP_ON = 1'b1;
`else
  localparam bit WRAP_ON = 1'b0;
`endif
  localparam logic [1:0] WRAP_RESP = WRAP_ON ? 2'b00 : 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready;
  logic        bvalid, bready, arvalid, arready;
  logic        rlast, rvalid, rready;

  always #5 clk = ~clk;

  axi_burst_slave_mem dut (
    .clk(clk), .reset(reset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] mm   [D];
  logic [31:0] wbuf [256];
  logic [3:0]  sbuf [256];

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    int          len;
    logic [1:0]  burst;
    logic [2:0]  size;
    int          wl;
    logic [1:0]  exp;
  } vec_t;

  vec_t vt [10];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic bit legal(input logic [2:0] size,
                               input logic [1:0] burst, input int len);
    if (size != 3'd2 || burst == 2'b11) return 1'b0;
    if (burst == 2'b10)
      return WRAP_ON && (len == 1 || len == 3 || len == 7 || len == 15);
    return 1'b1;
  endfunction

  function automatic int widx(input logic [31:0] addr,
                              input logic [1:0] burst, input int len,
                              input int i);
    int s, n, base;
    s = int'((addr >> 2) % D);
    n = len + 1;
    case (burst)
      2'b00:   return s;
      2'b10: begin
        base = s - (s % n);
        return base + ((s - base + i) % n);
      end
      default: return (s + i) % D;
    endcase
  endfunction

  task automatic model_write(input logic [31:0] addr, input int len,
                             input logic [1:0] burst, input logic [2:0] size);
    int k;
    if (!legal(size, burst, len)) return;
    for (int i = 0; i <= len; i++) begin
      k = widx(addr, burst, len, i);
      for (int b = 0; b < 4; b++)
        if (sbuf[i][b]) mm[k][8*b +: 8] = wbuf[i][8*b +: 8];
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr,
                          input int len, input logic [1:0] burst,
                          input logic [2:0] size, input int wl,
                          output logic [1:0] resp, output logic [3:0] id_o);
    int n;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = 8'(len);
    awsize = size; awburst = burst; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 200) begin @(negedge clk); n++; end
    chk("awready", awready, 1'b1);
    @(posedge clk); @(negedge clk);
    awvalid = 1'b0;
    chk("aw_to_wready", {awready, wready}, 2'b01);
    for (int i = 0; i <= len; i++) begin
      wdata = wbuf[i]; wstrb = sbuf[i];
      wlast = (wl < 0) ? (i == len) : (i == wl);
      wvalid = 1'b1;
      n = 0;
      while (!wready && n < 200) begin @(negedge clk); n++; end
      chk("wready", wready, 1'b1);
      @(posedge clk); @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0;
    chk("bvalid_next", {wready, bvalid}, 2'b01);
    resp = bresp; id_o = bid;
    bready = 1'b1;
    @(posedge clk); @(negedge clk);
    bready = 1'b0;
    chk("b_to_awready", {bvalid, awready}, 2'b01);
  endtask

  // mode: 0 rready high, 1 toggling, 2 random
  task automatic do_read(input logic [3:0] id, input logic [31:0] addr,
                         input int len, input logic [1:0] burst,
                         input logic [2:0] size, input int mode);
    int n, beat;
    bit ok, rr, stalled;
    logic [38:0] held;
    logic [31:0] exp;
    ok = legal(size, burst, len);
    @(negedge clk);
    arid = id; araddr = addr; arlen = 8'(len);
    arsize = size; arburst = burst; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 200) begin @(negedge clk); n++; end
    chk("arready", arready, 1'b1);
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0;
    chk("rvalid_first", {arready, rvalid}, 2'b01);
    beat = 0; stalled = 0; n = 0; held = '0;
    while (beat <= len && n < 2000) begin
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? bit'(n % 2) : bit'($urandom % 2);
      rready = rr;
      if (rvalid) begin
        if (stalled) chk("r_stable", {rdata, rlast, rid, rresp}, held);
        if (rr) begin
          exp = ok ? mm[widx(addr, burst, len, beat)] : 32'h0;
          chk("rdata", rdata, exp);
          chk("rlast", rlast, beat == len);
          chk("rid", rid, id);
          chk("rresp", rresp, ok ? 2'b00 : 2'b10);
          beat++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = {rdata, rlast, rid, rresp};
        end
      end
      @(posedge clk); @(negedge clk);
      n++;
    end
    rready = 1'b0;
    chk("r_beats", beat, len + 1);
    chk("r_end", {rvalid, arready}, 2'b01);
  endtask

  logic [1:0] resp;
  logic [3:0] idr;
  logic [3:0] rid_r;
  logic [31:0] ra;
  int len, wl;
  logic [1:0] bt;
  logic [2:0] sz;

  initial begin
    reset = 1'b1;
    {awid, awaddr, awlen, awsize, awburst, awvalid} = '0;
    {wdata, wstrb, wlast, wvalid, bready} = '0;
    {arid, araddr, arlen, arsize, arburst, arvalid, rready} = '0;
    repeat (3) @(negedge clk);
    chk("rst_ctl", {awready, wready, bvalid, arready, rvalid, rlast}, 6'b0);
    chk("rst_dat", {bid, bresp, rid, rdata, rresp}, 44'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {awready, arready}, 2'b11);

    // preload every word
    for (int i = 0; i < D; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    do_write(4'h0, 32'h0, D - 1, 2'b01, 3'd2, -1, resp, idr);
    chk("preload_resp", resp, 2'b00);
    model_write(32'h0, D - 1, 2'b01, 3'd2);

    // INCR burst, ID A, data 10..17
    for (int i = 0; i < 8; i++) begin wbuf[i] = 32'(10 + i); sbuf[i] = 4'hF; end
    do_write(4'hA, 32'h0, 7, 2'b01, 3'd2, -1, resp, idr);
    chk("incr_bresp", resp, 2'b00);
    chk("incr_bid", idr, 4'hA);
    model_write(32'h0, 7, 2'b01, 3'd2);
    do_read(4'hA, 32'h0, 7, 2'b01, 3'd2, 0);

    // byte strobes
    wbuf[0] = 32'h11111111; sbuf[0] = 4'hF;
    do_write(4'h1, 32'h4, 0, 2'b01, 3'd2, -1, resp, idr);
    model_write(32'h4, 0, 2'b01, 3'd2);
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'b0011;
    do_write(4'h1, 32'h4, 0, 2'b01, 3'd2, -1, resp, idr);
    model_write(32'h4, 0, 2'b01, 3'd2);
    do_read(4'h1, 32'h4, 0, 2'b01, 3'd2, 0);

    // 4-beat read, rready toggling
    do_read(4'h3, 32'h20, 3, 2'b01, 3'd2, 1);

    // early wlast on beat 3
    for (int i = 0; i < 8; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    do_write(4'h2, 32'h80, 7, 2'b01, 3'd2, 3, resp, idr);
    chk("wlast_early_resp", resp, 2'b10);
    model_write(32'h80, 7, 2'b01, 3'd2);
    do_read(4'h2, 32'h80, 7, 2'b01, 3'd2, 0);

    // WRAP at 0x8, len 3
    for (int i = 0; i < 4; i++) begin wbuf[i] = 32'hA0 + 32'(i); sbuf[i] = 4'hF; end
    do_write(4'h4, 32'h8, 3, 2'b10, 3'd2, -1, resp, idr);
    chk("wrap_resp", resp, WRAP_RESP);
    model_write(32'h8, 3, 2'b10, 3'd2);
    do_read(4'h4, 32'h0, 3, 2'b01, 3'd2, 0);

    // directed table
    vt[0] = '{4'd1, 32'h100,       3, 2'b01, 3'd2,  -1, 2'b00};
    vt[1] = '{4'd2, 32'h40,        0, 2'b00, 3'd2,  -1, 2'b00};
    vt[2] = '{4'd3, 32'h44,        3, 2'b00, 3'd2,  -1, 2'b00};
    vt[3] = '{4'd4, 32'h1FC,       1, 2'b01, 3'd2,  -1, 2'b00};
    vt[4] = '{4'd5, 32'h50,        3, 2'b01, 3'd1,  -1, 2'b10};
    vt[5] = '{4'd6, 32'h60,        2, 2'b11, 3'd2,  -1, 2'b10};
    vt[6] = '{4'd7, 32'h70,        3, 2'b01, 3'd2, 999, 2'b10};
    vt[7] = '{4'd8, 32'h34,        7, 2'b10, 3'd2,  -1, WRAP_RESP};
    vt[8] = '{4'd9, 32'h38,        2, 2'b10, 3'd2,  -1, 2'b10};
    vt[9] = '{4'hF, 32'h4000_0008, 0, 2'b01, 3'd2,   0, 2'b00};
    foreach (vt[v]) begin
      for (int i = 0; i <= vt[v].len; i++) begin
        wbuf[i] = $urandom; sbuf[i] = 4'($urandom);
      end
      do_write(vt[v].id, vt[v].addr, vt[v].len, vt[v].burst,
               vt[v].size, vt[v].wl, resp, idr);
      chk($sformatf("vec%0d_bresp", v), resp, vt[v].exp);
      chk($sformatf("vec%0d_bid", v), idr, vt[v].id);
      model_write(vt[v].addr, vt[v].len, vt[v].burst, vt[v].size);
      do_read(vt[v].id, vt[v].addr, vt[v].len, vt[v].burst, vt[v].size, 2);
    end

    // randomized bursts
    for (int t = 0; t < 40; t++) begin
      ra  = $urandom;
      len = $urandom_range(0, 15);
      bt  = ($urandom % 3 == 0) ? 2'($urandom) : 2'b01;
      sz  = ($urandom % 8 == 0) ? 3'd1 : 3'd2;
      wl  = ($urandom % 6 == 0) ? $urandom_range(0, len) : -1;
      rid_r = 4'($urandom);
      for (int i = 0; i <= len; i++) begin
        wbuf[i] = $urandom; sbuf[i] = 4'($urandom);
      end
      do_write(rid_r, ra, len, bt, sz, wl, resp, idr);
      chk("rnd_bresp", resp,
          (legal(sz, bt, len) && (wl < 0 || wl == len)) ? 2'b00 : 2'b10);
      chk("rnd_bid", idr, rid_r);
      model_write(ra, len, bt, sz);
      do_read(4'($urandom), $urandom, $urandom_range(0, 15),
              ($urandom % 3 == 0) ? 2'($urandom) : 2'b01, 3'd2, 2);
    end

    // reset during beat 2 of an 8-beat read
    @(negedge clk);
    arid = 4'h5; araddr = 32'h0; arlen = 8'd7;
    arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    @(posedge clk); @(negedge clk);
    arvalid = 1'b0; rready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("mid_rvalid", rvalid, 1'b1);
    reset = 1'b1;
    #1;
    chk("rst_async", {rvalid, arready, rlast, awready}, 4'b0);
    rready = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_release", arready, 1'b0);
    @(negedge clk);
    chk("arready_after_rel", arready, 1'b1);
    do_read(4'h5, 32'h0, 7, 2'b01, 3'd2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
